// File: rtl/vproc_xif_mem_responder.sv
// vproc_xif_mem_responder
//
// Memory-side responder for the vector unit's XIF memory interface. It answers
// LSU requests, flags access faults on out-of-range addresses in the request
// cycle, and forwards in-range requests onto a single OBI-style data bus. The
// IDs of forwarded requests are kept in an in-order FIFO. Each bus response
// pops one entry and produces one mem_result.
//
// Configuration macro:
//   VPROC_MEM_RESULT_REG_EN  defined   : mem_result fields are registered, so
//                                        the result follows data_rvalid_i by
//                                        exactly one cycle.
//                            undefined : mem_result is combinational from the
//                                        bus response and the FIFO head.
//
// Parameters:
//   XIF_ID_W        transaction ID width
//   MEM_W           data width (byte enables are MEM_W/8 wide)
//   MEM_BASE        first legal byte address
//   MEM_SIZE        legal region size in bytes
//   MAX_OUTSTANDING ID FIFO depth, must be 2 or more
//
// Ports:
//   clk_i, sync_rst_ni       clock, synchronous active-low reset
//   xif_mem_*                request channel from the LSU (valid/ready handshake)
//   xif_mem_resp_*           same-cycle access-fault response
//   xif_memres_*             in-order result channel, no backpressure
//   data_*                   OBI-style data bus towards the memory

module vproc_xif_mem_responder #(
    parameter int unsigned XIF_ID_W        = 3,
    parameter int unsigned MEM_W           = 32,
    parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE        = 32'h0001_0000,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk_i,
    input  logic                sync_rst_ni,

    // XIF memory request channel
    input  logic                xif_mem_valid_i,
    output logic                xif_mem_ready_o,
    input  logic [XIF_ID_W-1:0] xif_mem_id_i,
    input  logic [31:0]         xif_mem_addr_i,
    input  logic                xif_mem_we_i,
    input  logic [MEM_W/8-1:0]  xif_mem_be_i,
    input  logic [MEM_W-1:0]    xif_mem_wdata_i,
    output logic                xif_mem_resp_exc_o,
    output logic [5:0]          xif_mem_resp_exccode_o,

    // XIF memory result channel
    output logic                xif_memres_valid_o,
    output logic [XIF_ID_W-1:0] xif_memres_id_o,
    output logic [MEM_W-1:0]    xif_memres_rdata_o,
    output logic                xif_memres_err_o,

    // Data bus
    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic [31:0]         data_addr_o,
    output logic                data_we_o,
    output logic [MEM_W/8-1:0]  data_be_o,
    output logic [MEM_W-1:0]    data_wdata_o,
    input  logic                data_rvalid_i,
    input  logic [MEM_W-1:0]    data_rdata_i,
    input  logic                data_err_i
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [5:0] EXC_LOAD_FAULT  = 6'd5;
    localparam logic [5:0] EXC_STORE_FAULT = 6'd7;

    // Pointers wrap modulo the depth, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(MAX_OUTSTANDING - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Address range check
    // ------------------------------------------------------------------
    // Done in 33 bits so that MEM_BASE + MEM_SIZE == 2^32 needs no special case.
    logic [32:0] addr_ext;
    logic [32:0] addr_off;
    logic        in_range;

    always_comb begin
        addr_ext = {1'b0, xif_mem_addr_i};
        addr_off = addr_ext - {1'b0, MEM_BASE};
        in_range = (addr_ext >= {1'b0, MEM_BASE}) && (addr_off < {1'b0, MEM_SIZE});
    end

    // ------------------------------------------------------------------
    // ID FIFO state
    // ------------------------------------------------------------------
    logic [XIF_ID_W-1:0] fifo_id_q [MAX_OUTSTANDING];
    logic                fifo_we_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [XIF_ID_W-1:0] head_id;
    logic                head_we;

    assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign empty   = (count_q == '0);
    assign head_id = fifo_id_q[rd_ptr_q];
    assign head_we = fifo_we_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Request channel and bus request
    // ------------------------------------------------------------------
    // A full FIFO blocks the bus request even if a pop happens in the same
    // cycle, which keeps ready independent of data_rvalid_i.
    always_comb begin
        data_req_o      = xif_mem_valid_i & in_range & ~full;
        xif_mem_ready_o = xif_mem_valid_i & (~in_range | (data_gnt_i & ~full));

        xif_mem_resp_exc_o     = ~in_range;
        xif_mem_resp_exccode_o = '0;
        if (!in_range) begin
            xif_mem_resp_exccode_o = xif_mem_we_i ? EXC_STORE_FAULT : EXC_LOAD_FAULT;
        end
    end

    assign data_addr_o  = xif_mem_addr_i;
    assign data_we_o    = xif_mem_we_i;
    assign data_be_o    = xif_mem_be_i;
    assign data_wdata_o = xif_mem_wdata_i;

    assign push = data_req_o & data_gnt_i;
    // Responses arriving with nothing outstanding (e.g. for requests granted
    // before a reset) are dropped here.
    assign pop  = data_rvalid_i & ~empty;

    // ------------------------------------------------------------------
    // FIFO next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (sync_rst_ni && push) begin
            fifo_id_q[wr_ptr_q] <= xif_mem_id_i;
            fifo_we_q[wr_ptr_q] <= xif_mem_we_i;
        end
    end

    // ------------------------------------------------------------------
    // Result channel
    // ------------------------------------------------------------------
    logic                res_valid;
    logic [XIF_ID_W-1:0] res_id;
    logic [MEM_W-1:0]    res_rdata;
    logic                res_err;

    // Fields are zeroed whenever no result is produced.
    always_comb begin
        res_valid = pop;
        res_id    = '0;
        res_rdata = '0;
        res_err   = 1'b0;
        if (pop) begin
            res_id    = head_id;
            res_rdata = head_we ? '0 : data_rdata_i;
            res_err   = data_err_i;
        end
    end

`ifdef VPROC_MEM_RESULT_REG_EN
    logic                res_valid_q;
    logic [XIF_ID_W-1:0] res_id_q;
    logic [MEM_W-1:0]    res_rdata_q;
    logic                res_err_q;

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rdata_q <= '0;
            res_err_q   <= 1'b0;
        end else begin
            res_valid_q <= res_valid;
            res_id_q    <= res_id;
            res_rdata_q <= res_rdata;
            res_err_q   <= res_err;
        end
    end

    assign xif_memres_valid_o = res_valid_q;
    assign xif_memres_id_o    = res_id_q;
    assign xif_memres_rdata_o = res_rdata_q;
    assign xif_memres_err_o   = res_err_q;
`else
    // Held at zero while reset is asserted, matching the registered variant.
    always_comb begin
        xif_memres_valid_o = 1'b0;
        xif_memres_id_o    = '0;
        xif_memres_rdata_o = '0;
        xif_memres_err_o   = 1'b0;
        if (sync_rst_ni) begin
            xif_memres_valid_o = res_valid;
            xif_memres_id_o    = res_id;
            xif_memres_rdata_o = res_rdata;
            xif_memres_err_o   = res_err;
        end
    end
`endif

endmodule

// File: tb/tb_vproc_xif_mem_responder.sv
// Directed bench for vproc_xif_mem_responder with default parameters.
// Expected results go into a scoreboard when the bus response is driven; a
// negedge monitor pops and compares them, including the cycle of arrival.

module tb_vproc_xif_mem_responder;

`ifdef VPROC_MEM_RESULT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [2:0]  id;
        logic        we;
    } issue_t;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_id;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        resp_exc;
    logic [5:0]  resp_exccode;
    logic        res_valid;
    logic [2:0]  res_id;
    logic [31:0] res_rdata;
    logic        res_err;
    logic        d_req;
    logic        d_gnt;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    issue_t issued[$];
    res_t   sb[$];

    vproc_xif_mem_responder dut (
        .clk_i                  (clk),
        .sync_rst_ni            (rst_n),
        .xif_mem_valid_i        (mem_valid),
        .xif_mem_ready_o        (mem_ready),
        .xif_mem_id_i           (mem_id),
        .xif_mem_addr_i         (mem_addr),
        .xif_mem_we_i           (mem_we),
        .xif_mem_be_i           (mem_be),
        .xif_mem_wdata_i        (mem_wdata),
        .xif_mem_resp_exc_o     (resp_exc),
        .xif_mem_resp_exccode_o (resp_exccode),
        .xif_memres_valid_o     (res_valid),
        .xif_memres_id_o        (res_id),
        .xif_memres_rdata_o     (res_rdata),
        .xif_memres_err_o       (res_err),
        .data_req_o             (d_req),
        .data_gnt_i             (d_gnt),
        .data_addr_o            (d_addr),
        .data_we_o              (d_we),
        .data_be_o              (d_be),
        .data_wdata_o           (d_wdata),
        .data_rvalid_i          (d_rvalid),
        .data_rdata_i           (d_rdata),
        .data_err_i             (d_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: every result must match the scoreboard head, on time.
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {63'd0, res_valid}, 64'd0);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("res_id", {61'd0, res_id}, {61'd0, e.id});
                check("res_rdata", {32'd0, res_rdata}, {32'd0, e.rdata});
                check("res_err", {63'd0, res_err}, {63'd0, e.err});
                check("res_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic drive_req(input logic [2:0] id, input logic [31:0] addr, input logic we,
                             input logic gnt);
        mem_valid = 1'b1;
        mem_id    = id;
        mem_addr  = addr;
        mem_we    = we;
        mem_be    = 4'hF ^ {1'b0, id};
        mem_wdata = addr ^ 32'hA5A5_0000;
        d_gnt     = gnt;
    endtask

    // Bus response; the expected result is derived from the bench's own
    // record of granted requests.
    task automatic drive_rsp(input logic [31:0] rdata, input logic err);
        d_rvalid = 1'b1;
        d_rdata  = rdata;
        d_err    = err;
        if (issued.size() != 0) begin
            issue_t h;
            res_t   r;
            h = issued.pop_front();
            r.id    = h.id;
            r.rdata = h.we ? 32'd0 : rdata;
            r.err   = err;
            r.cyc   = cyc + LAT;
            sb.push_back(r);
        end
    endtask

    // Checks the combinational request-side outputs mid-cycle, records an
    // expected grant, then advances to just after the next rising edge.
    task automatic run_cycle(input string tag, input logic e_ready, input logic e_exc,
                             input logic [5:0] e_code, input logic e_req);
        @(negedge clk);
        check({tag, "_ready"}, {63'd0, mem_ready}, {63'd0, e_ready});
        check({tag, "_req"}, {63'd0, d_req}, {63'd0, e_req});
        if (mem_valid) begin
            check({tag, "_exc"}, {63'd0, resp_exc}, {63'd0, e_exc});
            check({tag, "_exccode"}, {58'd0, resp_exccode}, {58'd0, e_code});
        end
        if (e_req) begin
            check({tag, "_addr"}, {32'd0, d_addr}, {32'd0, mem_addr});
            check({tag, "_wdata"}, {32'd0, d_wdata}, {32'd0, mem_wdata});
            check({tag, "_be"}, {60'd0, d_be}, {60'd0, mem_be});
            check({tag, "_we"}, {63'd0, d_we}, {63'd0, mem_we});
        end
        if (mem_valid && e_ready && !e_exc) begin
            issue_t n;
            n.id = mem_id;
            n.we = mem_we;
            issued.push_back(n);
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_err     = 1'b0;
    endtask

    task automatic idle(input string tag);
        run_cycle(tag, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        mem_id    = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        d_err     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", {63'd0, res_valid}, 64'd0);
        check("rst_id", {61'd0, res_id}, 64'd0);
        check("rst_rdata", {32'd0, res_rdata}, 64'd0);
        check("rst_err", {63'd0, res_err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle("post_rst");

        // Single load, response two cycles after the grant
        drive_req(3'd3, 32'h100, 1'b0, 1'b1);
        run_cycle("t1_req", 1'b1, 1'b0, 6'd0, 1'b1);
        idle("t1_gap");
        drive_rsp(32'hDEAD_BEEF, 1'b0);
        run_cycle("t1_rsp", 1'b0, 1'b0, 6'd0, 1'b0);
        idle("t1_tail");
        check("t1_drained", 64'(sb.size()), 64'd0);

        // Access faults: accepted without a grant and never forwarded
        drive_req(3'd5, 32'h0001_0000, 1'b1, 1'b0);
        run_cycle("t2_store", 1'b1, 1'b1, 6'd7, 1'b0);
        drive_req(3'd5, 32'h0001_0000, 1'b0, 1'b0);
        run_cycle("t2_load", 1'b1, 1'b1, 6'd5, 1'b0);
        drive_req(3'd1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_cycle("t2_top", 1'b1, 1'b1, 6'd7, 1'b0);
        drive_req(3'd1, 32'h0000_FFFC, 1'b0, 1'b0);
        run_cycle("t2_last_nognt", 1'b0, 1'b0, 6'd0, 1'b1);
        idle("t2_tail");
        check("t2_no_result", 64'(sb.size()), 64'd0);

        // Fill the FIFO, then check that a pop does not admit a push-through
        for (int i = 0; i < 4; i++) begin
            drive_req(3'(i), 32'h400 + 32'(4 * i), 1'b0, 1'b1);
            run_cycle("t3_fill", 1'b1, 1'b0, 6'd0, 1'b1);
        end
        drive_req(3'd4, 32'h410, 1'b0, 1'b1);
        run_cycle("t3_full", 1'b0, 1'b0, 6'd0, 1'b0);
        drive_req(3'd4, 32'h410, 1'b0, 1'b1);
        drive_rsp(32'h1111_0000, 1'b0);
        run_cycle("t3_full_pop", 1'b0, 1'b0, 6'd0, 1'b0);
        drive_req(3'd4, 32'h410, 1'b0, 1'b1);
        run_cycle("t3_after_pop", 1'b1, 1'b0, 6'd0, 1'b1);
        for (int i = 1; i < 5; i++) begin
            drive_rsp(32'h1111_0000 + 32'(i), 1'b0);
            run_cycle("t3_drain", 1'b0, 1'b0, 6'd0, 1'b0);
        end
        idle("t3_tail");
        check("t3_drained", 64'(sb.size()), 64'd0);

        // Store then load; the store result carries no data, the load an error
        drive_req(3'd2, 32'h200, 1'b1, 1'b1);
        run_cycle("t4_st", 1'b1, 1'b0, 6'd0, 1'b1);
        drive_req(3'd6, 32'h204, 1'b0, 1'b1);
        run_cycle("t4_ld", 1'b1, 1'b0, 6'd0, 1'b1);
        drive_rsp(32'h5555_AAAA, 1'b0);
        run_cycle("t4_rsp0", 1'b0, 1'b0, 6'd0, 1'b0);
        drive_rsp(32'h7777_0001, 1'b1);
        run_cycle("t4_rsp1", 1'b0, 1'b0, 6'd0, 1'b0);
        idle("t4_tail");
        check("t4_drained", 64'(sb.size()), 64'd0);

        // Spurious response on an empty FIFO, then prove the count is still 0
        drive_rsp(32'hBAD0_0000, 1'b1);
        run_cycle("t5_spurious", 1'b0, 1'b0, 6'd0, 1'b0);
        idle("t5_gap");
        for (int i = 0; i < 4; i++) begin
            drive_req(3'(7 - i), 32'h500 + 32'(4 * i), 1'b0, 1'b1);
            run_cycle("t5_fill", 1'b1, 1'b0, 6'd0, 1'b1);
        end
        drive_req(3'd0, 32'h520, 1'b0, 1'b1);
        run_cycle("t5_full", 1'b0, 1'b0, 6'd0, 1'b0);
        drive_rsp(32'h5000_0001, 1'b0);
        run_cycle("t5_pop0", 1'b0, 1'b0, 6'd0, 1'b0);
        drive_rsp(32'h5000_0002, 1'b0);
        run_cycle("t5_pop1", 1'b0, 1'b0, 6'd0, 1'b0);
        idle("t5_pre_rst");

        // Reset with two outstanding; their late responses must be dropped
        rst_n = 1'b0;
        issued.delete();
        run_cycle("t5_rst0", 1'b0, 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        check("t5_rst_valid", {63'd0, res_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_rsp(32'h6000_0001, 1'b0);
        run_cycle("t5_late0", 1'b0, 1'b0, 6'd0, 1'b0);
        drive_rsp(32'h6000_0002, 1'b0);
        run_cycle("t5_late1", 1'b0, 1'b0, 6'd0, 1'b0);
        drive_req(3'd5, 32'h600, 1'b0, 1'b1);
        run_cycle("t5_fresh", 1'b1, 1'b0, 6'd0, 1'b1);
        drive_rsp(32'h6000_0003, 1'b0);
        run_cycle("t5_fresh_rsp", 1'b0, 1'b0, 6'd0, 1'b0);
        idle("t5_tail");
        check("t5_drained", 64'(sb.size()), 64'd0);

        // Simultaneous push and pop at count 2, long enough to wrap pointers
        drive_req(3'd1, 32'h700, 1'b0, 1'b1);
        run_cycle("t6_pre0", 1'b1, 1'b0, 6'd0, 1'b1);
        drive_req(3'd2, 32'h704, 1'b1, 1'b1);
        run_cycle("t6_pre1", 1'b1, 1'b0, 6'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive_req(3'((3 + i) % 8), 32'h708 + 32'(4 * i), 1'(i % 3 == 0), 1'b1);
            drive_rsp(32'h7000_0000 + 32'(i), 1'(i == 4));
            run_cycle("t6_pushpop", 1'b1, 1'b0, 6'd0, 1'b1);
        end
        drive_req(3'd0, 32'h800, 1'b0, 1'b1);
        run_cycle("t6_notfull", 1'b1, 1'b0, 6'd0, 1'b1);
        drive_req(3'd1, 32'h804, 1'b0, 1'b1);
        run_cycle("t6_fill4", 1'b1, 1'b0, 6'd0, 1'b1);
        drive_req(3'd2, 32'h808, 1'b0, 1'b1);
        run_cycle("t6_full", 1'b0, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_rsp(32'h7100_0000 + 32'(i), 1'b0);
            run_cycle("t6_drain", 1'b0, 1'b0, 6'd0, 1'b0);
        end
        idle("t6_tail0");
        idle("t6_tail1");
        check("t6_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
